// File: rtl/ldtu_link_ctrl.sv
// Output-link sequencer for the LiTE-DTU: synch pattern, encoder/FIFO flush, then data,
// with calibration and ATU test modes overriding the normal bring-up.
module ldtu_link_ctrl #(
    parameter int SYNCH_MIN    = 16,
    parameter int FLUSH_CYCLES = 4,
    parameter int CNT_BITS     = 5
) (
    input  logic       CLK,
    input  logic       RST_b,
    input  logic       CALIBRATION_BUSY,
    input  logic       TEST_ENABLE,
    input  logic       synch_start,
    input  logic       synch_stop,
    input  logic       flush_req,
    output logic       synch,
    output logic       flush_b,
    output logic       run,
    output logic       atu_sel,
    output logic [2:0] state,
    output logic [7:0] flush_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNCH = 3'd1,
        ST_FLUSH = 3'd2,
        ST_RUN   = 3'd3,
        ST_CALIB = 3'd4,
        ST_TEST  = 3'd5
    } state_t;

    localparam logic [CNT_BITS-1:0] SYNCH_MIN_C  = CNT_BITS'(SYNCH_MIN);
    localparam logic [CNT_BITS-1:0] FLUSH_LAST_C = CNT_BITS'(FLUSH_CYCLES);

    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                stop_pend_q, stop_pend_d;
    logic [7:0]          flush_cnt_q, flush_cnt_d;
    logic                synch_q, synch_d;
    logic                flush_b_q, flush_b_d;
    logic                run_q, run_d;
    logic                atu_sel_q, atu_sel_d;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v,
                                                    input logic [CNT_BITS-1:0] lim);
        return (v >= lim) ? lim : v + CNT_BITS'(1);
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stop_pend_d = stop_pend_q;
        flush_cnt_d = flush_cnt_q;

        if (CALIBRATION_BUSY) begin
            state_d = ST_CALIB;
        end else if (TEST_ENABLE) begin
            state_d = ST_TEST;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_SYNCH;
                ST_SYNCH: begin
                    // cnt_d is the number of SYNCH cycles completed at this edge,
                    // so the exit lands after exactly SYNCH_MIN cycles.
                    cnt_d = sat_inc(cnt_q, SYNCH_MIN_C);
                    if (synch_stop) stop_pend_d = 1'b1;
                    if ((cnt_d == SYNCH_MIN_C) && (stop_pend_q || synch_stop))
                        state_d = ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (synch_start) begin
                        state_d = ST_SYNCH;
                    end else begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                        if (cnt_d == FLUSH_LAST_C) begin
                            state_d     = ST_RUN;
                            flush_cnt_d = flush_cnt_q + 8'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (synch_start)    state_d = ST_SYNCH;
                    else if (flush_req) state_d = ST_FLUSH;
                end
                ST_CALIB: state_d = ST_SYNCH;
                ST_TEST:  state_d = ST_SYNCH;
                default:  state_d = ST_IDLE;
            endcase
        end

        if (state_d != state_q) begin
            cnt_d       = '0;
            stop_pend_d = 1'b0;
        end

        synch_d   = (state_d == ST_SYNCH);
        flush_b_d = (state_d != ST_FLUSH);
        run_d     = (state_d == ST_RUN);
        atu_sel_d = (state_d == ST_TEST);
    end

    always_ff @(posedge CLK or negedge RST_b) begin
        if (!RST_b) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            stop_pend_q <= 1'b0;
            flush_cnt_q <= 8'd0;
            synch_q     <= 1'b0;
            flush_b_q   <= 1'b1;
            run_q       <= 1'b0;
            atu_sel_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stop_pend_q <= stop_pend_d;
            flush_cnt_q <= flush_cnt_d;
            synch_q     <= synch_d;
            flush_b_q   <= flush_b_d;
            run_q       <= run_d;
            atu_sel_q   <= atu_sel_d;
        end
    end

    assign state     = state_q;
    assign flush_cnt = flush_cnt_q;
    assign synch     = synch_q;
    assign flush_b   = flush_b_q;
    assign run       = run_q;
    assign atu_sel   = atu_sel_q;

endmodule

// File: tb/tb_ldtu_link_ctrl.sv
// Scoreboard bench for ldtu_link_ctrl: the driver queues the expected state/flush count
// for each checked edge, a monitor pops and compares just after every rising edge.
module tb_ldtu_link_ctrl;

    logic       CLK = 1'b0;
    logic       RST_b;
    logic       CALIBRATION_BUSY;
    logic       TEST_ENABLE;
    logic       synch_start;
    logic       synch_stop;
    logic       flush_req;
    logic       synch;
    logic       flush_b;
    logic       run;
    logic       atu_sel;
    logic [2:0] state;
    logic [7:0] flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0] st;
        logic [7:0] fc;
        string      nm;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    ldtu_link_ctrl #(.SYNCH_MIN(16), .FLUSH_CYCLES(4), .CNT_BITS(5)) dut (
        .CLK              (CLK),
        .RST_b            (RST_b),
        .CALIBRATION_BUSY (CALIBRATION_BUSY),
        .TEST_ENABLE      (TEST_ENABLE),
        .synch_start      (synch_start),
        .synch_stop       (synch_stop),
        .flush_req        (flush_req),
        .synch            (synch),
        .flush_b          (flush_b),
        .run              (run),
        .atu_sel          (atu_sel),
        .state            (state),
        .flush_cnt        (flush_cnt)
    );

    always #5 CLK = ~CLK;

    // Outputs are a pure function of the state code, plus the flush count.
    task automatic check(input exp_t e);
        logic [14:0] act, want;
        act  = {state, synch, flush_b, run, atu_sel, flush_cnt};
        want = {e.st, (e.st == 3'd1), (e.st != 3'd2), (e.st == 3'd3), (e.st == 3'd5), e.fc};
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got state=%0d synch=%0b flush_b=%0b run=%0b atu_sel=%0b flush_cnt=%0d, want state=%0d synch=%0b flush_b=%0b run=%0b atu_sel=%0b flush_cnt=%0d",
                     e.nm, state, synch, flush_b, run, atu_sel, flush_cnt,
                     want[14:12], want[11], want[10], want[9], want[8], want[7:0]);
        end
    endtask

    task automatic check_now(input logic [2:0] st, input logic [7:0] fc, input string nm);
        exp_t e;
        e.st = st; e.fc = fc; e.nm = nm;
        check(e);
    endtask

    always @(posedge CLK) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check(mon_e);
        end
    end

    // Queue the expectation for the next rising edge, then advance to the following falling edge.
    task automatic step(input logic [2:0] st, input logic [7:0] fc, input string nm);
        exp_t e;
        e.st = st; e.fc = fc; e.nm = nm;
        exp_q.push_back(e);
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Called just after SYNCH entry: stop arrives on the first SYNCH edge, exit lands on edge 16.
    task automatic synch_to_flush(input logic [7:0] fc);
        synch_stop = 1'b1;
        step(3'd1, fc, "synch_dwell");
        synch_stop = 1'b0;
        repeat (14) step(3'd1, fc, "synch_dwell");
        step(3'd2, fc, "synch_exit_at_16");
    endtask

    task automatic flush_rest(input logic [7:0] fc);
        repeat (3) step(3'd2, fc, "flush_low");
        step(3'd3, 8'(fc + 8'd1), "flush_done_run");
    endtask

    initial begin
        RST_b = 1'b0; CALIBRATION_BUSY = 1'b0; TEST_ENABLE = 1'b0;
        synch_start = 1'b0; synch_stop = 1'b0; flush_req = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check_now(3'd0, 8'd0, "reset_values");
        RST_b = 1'b1;

        // Reset release, no commands: one IDLE edge, then SYNCH indefinitely.
        step(3'd1, 8'd0, "idle_to_synch");
        repeat (24) step(3'd1, 8'd0, "synch_hold");
        synch_stop = 1'b1;
        step(3'd2, 8'd0, "stop_after_saturation");
        synch_stop = 1'b0;
        flush_rest(8'd0);
        step(3'd3, 8'd1, "run_hold");

        // Early stop at SYNCH cycle 3, plus synch_start ignored inside SYNCH.
        synch_start = 1'b1;
        step(3'd1, 8'd1, "start_from_run");
        synch_start = 1'b0;
        repeat (2) step(3'd1, 8'd1, "synch_dwell");
        synch_stop = 1'b1;
        step(3'd1, 8'd1, "early_stop_held");
        synch_stop = 1'b0;
        step(3'd1, 8'd1, "synch_dwell");
        synch_start = 1'b1;
        step(3'd1, 8'd1, "start_ignored_in_synch");
        synch_start = 1'b0;
        repeat (10) step(3'd1, 8'd1, "synch_dwell");
        step(3'd2, 8'd1, "early_stop_exit_16");
        flush_rest(8'd1);

        // RUN commands.
        flush_req = 1'b1;
        step(3'd2, 8'd2, "flush_req_from_run");
        step(3'd2, 8'd2, "flush_req_ignored_in_flush");
        flush_req = 1'b0;
        repeat (2) step(3'd2, 8'd2, "flush_low");
        step(3'd3, 8'd3, "run_fc3");
        synch_start = 1'b1; flush_req = 1'b1;
        step(3'd1, 8'd3, "start_wins_over_flush");
        synch_start = 1'b0; flush_req = 1'b0;

        // Calibration at FLUSH cycle 2.
        synch_to_flush(8'd3);
        step(3'd2, 8'd3, "flush_low");
        CALIBRATION_BUSY = 1'b1;
        step(3'd4, 8'd3, "calib_mid_flush");
        repeat (9) step(3'd4, 8'd3, "calib_hold");
        CALIBRATION_BUSY = 1'b0;
        step(3'd1, 8'd3, "calib_exit_to_synch");
        synch_to_flush(8'd3);
        synch_start = 1'b1;
        step(3'd1, 8'd3, "start_aborts_flush");
        synch_start = 1'b0;
        synch_to_flush(8'd3);
        flush_rest(8'd3);

        // Test mode with calibration priority.
        TEST_ENABLE = 1'b1;
        step(3'd5, 8'd4, "test_from_run");
        repeat (2) step(3'd5, 8'd4, "test_hold");
        CALIBRATION_BUSY = 1'b1;
        step(3'd4, 8'd4, "calib_over_test");
        step(3'd4, 8'd4, "calib_hold");
        CALIBRATION_BUSY = 1'b0;
        step(3'd5, 8'd4, "test_after_calib");
        TEST_ENABLE = 1'b0;
        step(3'd1, 8'd4, "test_exit_to_synch");

        // Flush counter wrap.
        synch_to_flush(8'd4);
        flush_rest(8'd4);
        for (int i = 0; i < 250; i++) begin
            flush_req = 1'b1;
            idle(1);
            flush_req = 1'b0;
            idle(4);
        end
        step(3'd3, 8'd255, "flush_cnt_255");
        flush_req = 1'b1;
        step(3'd2, 8'd255, "flush_req_from_run");
        flush_req = 1'b0;
        flush_rest(8'd255);

        // Asynchronous reset mid-SYNCH, between clock edges.
        synch_start = 1'b1;
        step(3'd1, 8'd0, "start_after_wrap");
        synch_start = 1'b0;
        repeat (3) step(3'd1, 8'd0, "synch_pre_reset");
        #2;
        RST_b = 1'b0;
        #1;
        check_now(3'd0, 8'd0, "async_reset_immediate");
        @(negedge CLK);
        check_now(3'd0, 8'd0, "reset_held_over_edge");
        RST_b = 1'b1;
        step(3'd1, 8'd0, "synch_after_reset");

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge CLK);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want finish before 500000 ns");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ldtu_link_ctrl.md
# ldtu_link_ctrl

Link-state sequencer for the LiTE-DTU output path. It runs the ordered bring-up of the serial link: send synch pattern, flush the encoder/CU/output FIFO, then stream data. It also parks the path during calibration and hands the output mux to the ATU during test. It sits beside the top level and drives the `synch`, `flush_b` and mux-select controls of the output FIFO and the ATU/DTU mux, from fast commands and the calibration/test status lines.

## Interface
- `SYNCH_MIN`, default 16: minimum number of cycles spent in SYNCH before a stop is honoured.
- `FLUSH_CYCLES`, default 4: number of cycles `flush_b` is held low per flush.
- `CNT_BITS`, default 5: cycle-counter width. It must hold max(`SYNCH_MIN`, `FLUSH_CYCLES`).
- `CLK` input 1: 160 MHz system clock. This is the block's only clock.
- `RST_b` input 1: reset, asynchronous and active-low.
- `CALIBRATION_BUSY` input 1: OR of the g01 and g10 calibration-busy lines. Level signal.
- `TEST_ENABLE` input 1: ATU test mode. Level signal.
- `synch_start` input 1: one-cycle command, enter SYNCH.
- `synch_stop` input 1: one-cycle command, leave SYNCH.
- `flush_req` input 1: one-cycle command, flush while in RUN.
- `synch` output 1: output FIFO sends `synch_pattern` while this is high.
- `flush_b` output 1: active-low flush to the encoder, CU and output FIFO.
- `run` output 1: data path is streaming.
- `atu_sel` output 1: output mux selects the ATU data words.
- `state` output 3: current state code.
- `flush_cnt` output 8: number of completed flushes. Wraps at 255→0.

## Operation
State codes: IDLE=0, SYNCH=1, FLUSH=2, RUN=3, CALIB=4, TEST=5.

Transitions, evaluated every `CLK` edge in priority order:
1. `CALIBRATION_BUSY`=1 → CALIB, from any state.
2. Otherwise `TEST_ENABLE`=1 → TEST, from any state.
3. Otherwise, per state:
   - IDLE: always → SYNCH on the next edge, so IDLE lasts 1 cycle after reset release.
   - SYNCH: the counter increments and saturates at `SYNCH_MIN`.
     - `synch_stop` sets a `stop_pend` flag.
     - Exit to FLUSH occurs once the counter equals `SYNCH_MIN` and either `stop_pend`=1 or `synch_stop`=1 in that cycle.
     - A stop received early is therefore remembered. `synch_start` in SYNCH is ignored.
   - FLUSH: the counter counts 1..`FLUSH_CYCLES`, then → RUN.
     - `flush_cnt` increments on the FLUSH→RUN transition.
     - `synch_start` in FLUSH → SYNCH, aborting the flush without incrementing `flush_cnt`.
     - `flush_req` in FLUSH is ignored.
   - RUN: `synch_start` → SYNCH. Otherwise `flush_req` → FLUSH. If both arrive in the same cycle, `synch_start` wins.
   - CALIB: when `CALIBRATION_BUSY` falls, → SYNCH (`TEST_ENABLE` permitting).
   - TEST: when `TEST_ENABLE` falls, → SYNCH.

Counter and flag rules:
- Every state entry clears the counter and `stop_pend`.
- `synch_stop` outside SYNCH is ignored.

Outputs (Moore, decoded from the next state and registered):
- `synch`=1 only in SYNCH.
- `flush_b`=0 only in FLUSH.
- `run`=1 only in RUN.
- `atu_sel`=1 only in TEST.
- `state` equals the state register.

## Timing
- Reset values: `state`=0, `synch`=0, `flush_b`=1, `run`=0, `atu_sel`=0, `flush_cnt`=0, counter=0, `stop_pend`=0.
- All outputs change on the same edge as the state register. There is no combinational path from inputs to outputs.
- Command latency: a command sampled at edge N changes the state and outputs at edge N. The outputs are visible in cycle N+1.
- SYNCH dwell is max(`SYNCH_MIN`, time to `synch_stop`) cycles. With the stop pending early, the dwell is exactly `SYNCH_MIN` cycles.
- FLUSH dwell is exactly `FLUSH_CYCLES` cycles of `flush_b`=0. `run` rises on the edge `flush_b` returns to 1.
- Reset asserted mid-sequence forces all reset values immediately (asynchronously). After release, the block does 1 IDLE cycle, then SYNCH.
- `CALIBRATION_BUSY` asserted mid-FLUSH: `flush_b` returns to 1 on the next edge and `flush_cnt` is unchanged.

## Test plan
- **Reset release, no commands:** `state` goes 0 → 1 after 1 cycle. `synch`=1 stays high indefinitely. The counter saturates at 16.
- **Early stop:** `synch_stop` at SYNCH cycle 3 → exit at cycle 16. `flush_b` is low for exactly 4 cycles, then `run`=1 and `flush_cnt`=1.
- **RUN commands:** `flush_req` alone → 4-cycle flush and `flush_cnt`=2. `synch_start` and `flush_req` in the same cycle → SYNCH, `flush_b` stays 1.
- **Calibration mid-FLUSH:** `CALIBRATION_BUSY` pulsed high for 10 cycles at FLUSH cycle 2 → `state`=4, `flush_b`=1, `flush_cnt` unchanged. After the fall → SYNCH with counter reset.
- **Test with calibration priority:** `TEST_ENABLE` high in RUN → `atu_sel`=1, `run`=0. `CALIBRATION_BUSY` raised while in TEST → `state`=4, `atu_sel`=0.
- **Flush counter wrap and async reset:** 256 flushes → `flush_cnt` wraps to 0. `RST_b` pulsed low mid-SYNCH → all outputs reset immediately, without waiting for a clock edge.
